uart_rx_deframer: RTL and testbench
===================================

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per character.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: line rate in bit/s.
REQ-003 SHALL have parameter CLOCK_SPEED, default 100000000: clk frequency in Hz.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rtx, input, 1: asynchronous serial receive line from the pad; idles high.
REQ-007 SHALL have port data_o, output, DATA_WIDTH: received character.
REQ-008 SHALL have port valid_o, output, 1: data_o holds an unread character.
REQ-009 SHALL have port ready_i, input, 1: consumer accepts data_o when valid_o is high.
REQ-010 SHALL have port frame_err_o, output, 1: one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port overrun_o, output, 1: one-cycle pulse when a completed character is dropped.
REQ-012 SHALL have port busy_o, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL define CLKS_PER_BIT = CLOCK_SPEED/BAUD_RATE (integer division) and HALF_BIT = CLKS_PER_BIT/2.
REQ-014 SHALL pass rtx through a 2-flop synchronizer; both flops SHALL reset to 1; all decisions SHALL use the synchronized value.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-016 IDLE: synchronized line low -> START, bit-timer cleared.
REQ-017 START: at timer = HALF_BIT-1, line low -> DATA with timer and bit index cleared; line high -> IDLE (glitch rejection, nothing reported).
REQ-018 DATA: at timer = CLKS_PER_BIT-1, sample the line into the shift register LSB first; after DATA_WIDTH samples -> STOP.
REQ-019 STOP: at timer = CLKS_PER_BIT-1, line high -> push character, go to IDLE; line low -> pulse frame_err_o, discard character, go to WAIT_IDLE.
REQ-020 WAIT_IDLE: remain until the synchronized line is high, then IDLE; a held break SHALL produce exactly one frame_err_o.
REQ-021 valid_o SHALL rise in the cycle after the stop-bit sample cycle.
REQ-022 A transfer SHALL occur on a rising clk edge where valid_o and ready_i are both high; data_o SHALL stay stable while valid_o is high and ready_i is low.
REQ-023 Push and pop in the same cycle SHALL both complete; no overrun SHALL be reported.
REQ-024 Push while storage is full with no pop SHALL pulse overrun_o, drop the new character, and keep the stored data unchanged.

Reset
REQ-025 rst low SHALL immediately force: FSM to IDLE, timers and bit index to 0, shift register and storage to 0, synchronizer flops to 1.
REQ-026 While rst is low: data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no pulses; reception SHALL resume with the next start bit after release.

Configuration
REQ-028 Macro UART_RX_FIFO_EN defined: storage SHALL be a 4-entry FIFO in arrival order; data_o SHALL show the head entry; full means 4 entries.
REQ-029 Macro UART_RX_FIFO_EN undefined: storage SHALL be a single holding register; full means valid_o is high.

Verification (CLOCK_SPEED=1600, BAUD_RATE=100, so CLKS_PER_BIT=16)
REQ-030 Frame 0xA5, stop=1, ready_i=1 -> exactly one valid_o cycle with data_o=0xA5, no error pulses, busy_o low afterwards.
REQ-031 rtx low for 4 clks, then high -> no valid_o, no frame_err_o, busy_o back low within 12 clks.
REQ-032 Frame 0x3C with stop=0, then rtx held low 100 clks -> exactly one frame_err_o pulse, no valid_o, FSM leaves WAIT_IDLE only after rtx returns high.
REQ-033 ready_i=0, send 0x11 then 0x22 -> without FIFO: one overrun_o pulse, data_o stays 0x11; with FIFO: no overrun, reads return 0x11 then 0x22.
REQ-034 FIFO build, ready_i=0, send 0x01..0x05 -> overrun_o pulses on 0x05 only; draining returns 0x01..0x04.
REQ-035 rst low in the middle of DATA for 0x5A, then release, then send 0xC3 -> no output for 0x5A, data_o=0xC3 received correctly.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 2-flop synchronizer, start/data/stop framing FSM, output storage.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register is used.
module uart_rx_deframer #(
  parameter int DATA_WIDTH  = 8,
  parameter int BAUD_RATE   = 115200,
  parameter int CLOCK_SPEED = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rtx,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT + 1);
  localparam int IW           = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(HALF_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   sync1_q, sync2_q;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q;
  logic                   push, pop, full;
  logic                   line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rtx;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!line) state_d = START;
      end
      START: begin
        if (timer_q == HALF_END) begin
          timer_d   = '0;
          bit_idx_d = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d   = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          shift_d = {line, shift_q[DATA_WIDTH-1:1]};
          if (bit_idx_q == LAST_IDX) state_d = STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          if (line) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        timer_d = '0;
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = valid_o && ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overrun_q <= 1'b0;
    else      overrun_q <= push && full && !pop;
  end

`ifdef UART_RX_FIFO_EN
  logic [DATA_WIDTH-1:0] mem_q [4];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            count_q;
  logic                  wr_en;

  assign full    = (count_q == 3'd4);
  assign valid_o = (count_q != 3'd0);
  assign data_o  = mem_q[rd_ptr_q];
  // When full, a simultaneous pop frees the head slot that wr_ptr points at.
  assign wr_en   = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_valid_q;

  assign full    = hold_valid_q;
  assign valid_o = hold_valid_q;
  assign data_o  = hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (push && (!hold_valid_q || pop)) begin
      hold_q       <= shift_q;
      hold_valid_q <= 1'b1;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer at 16 clocks per bit; covers both storage builds.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rtx = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] exp_q [$];

  uart_rx_deframer #(.DATA_WIDTH(8), .BAUD_RATE(100), .CLOCK_SPEED(1600)) dut (
    .clk(clk), .rst(rst), .rtx(rtx), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Low stop bit leaves the line low through the gap.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    rtx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rtx = d[i];
      tick(16);
    end
    rtx = stop;
    tick(16);
    if (stop) rtx = 1'b1;
    tick(gap);
  endtask

  // Monitor: pop expected character on every transfer, tally pulses.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (valid_o && ready_i) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_data: got %0h expected none", data_o);
          end else begin
            e = exp_q.pop_front();
            check("data_o", {24'd0, data_o}, {24'd0, e});
          end
        end
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int waited;
    int exp_xfers;
    tick(3);
    check("rst_data", {24'd0, data_o}, 32'h0);
    check("rst_valid", {31'd0, valid_o}, 32'h0);
    check("rst_ferr", {31'd0, frame_err_o}, 32'h0);
    check("rst_ovr", {31'd0, overrun_o}, 32'h0);
    check("rst_busy", {31'd0, busy_o}, 32'h0);
    rst = 1'b1;
    tick(5);

    // Clean frame
    ready_i = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 20);
    check("a5_busy", {31'd0, busy_o}, 32'h0);
    check("a5_xfers", xfer_cnt, 1);
    check("a5_ferr", ferr_cnt, 0);
    check("a5_ovr", ovr_cnt, 0);

    // Short low glitch is rejected
    rtx = 1'b0;
    tick(4);
    rtx = 1'b1;
    waited = 0;
    while (busy_o && waited < 12) begin
      tick(1);
      waited++;
    end
    check("glitch_busy", {31'd0, busy_o}, 32'h0);
    tick(20);
    check("glitch_xfers", xfer_cnt, 1);
    check("glitch_ferr", ferr_cnt, 0);

    // Framing error followed by held break
    send_frame(8'h3C, 1'b0, 84);
    check("brk_busy_held", {31'd0, busy_o}, 32'h1);
    check("brk_ferr", ferr_cnt, 1);
    rtx = 1'b1;
    tick(6);
    check("brk_busy_released", {31'd0, busy_o}, 32'h0);
    check("brk_ferr_after", ferr_cnt, 1);
    check("brk_xfers", xfer_cnt, 1);

    // Two characters with the consumer stalled
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 8);
    send_frame(8'h22, 1'b1, 8);
    check("stall_valid", {31'd0, valid_o}, 32'h1);
    check("stall_head", {24'd0, data_o}, 32'h11);
`ifdef UART_RX_FIFO_EN
    check("stall_ovr", ovr_cnt, 0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
`else
    check("stall_ovr", ovr_cnt, 1);
    exp_q.push_back(8'h11);
`endif
    ready_i = 1'b1;
    tick(6);
    ready_i = 1'b0;
    check("stall_drained", {31'd0, valid_o}, 32'h0);

    // Five characters into stalled storage
    for (int i = 1; i <= 5; i++) begin
      send_frame(i[7:0], 1'b1, 4);
`ifdef UART_RX_FIFO_EN
      check("fill_ovr", ovr_cnt, (i == 5) ? 1 : 0);
`else
      check("fill_ovr", ovr_cnt, 1 + i - 1);
`endif
    end
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 4; i++) exp_q.push_back(i[7:0]);
`else
    exp_q.push_back(8'h01);
`endif
    ready_i = 1'b1;
    tick(8);
    check("fill_drained", {31'd0, valid_o}, 32'h0);

    // Reset in the middle of DATA
    rtx = 1'b0;
    tick(16);
    rtx = 1'b0;
    tick(16);
    rtx = 1'b1;
    tick(16);
    rtx = 1'b0;
    tick(8);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy_o}, 32'h0);
    check("mid_rst_valid", {31'd0, valid_o}, 32'h0);
    check("mid_rst_data", {24'd0, data_o}, 32'h0);
    rtx = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(20);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 20);
`ifdef UART_RX_FIFO_EN
    exp_xfers = 8;
    check("final_ovr", ovr_cnt, 1);
`else
    exp_xfers = 4;
    check("final_ovr", ovr_cnt, 5);
`endif
    check("final_xfers", xfer_cnt, exp_xfers);
    check("final_ferr", ferr_cnt, 1);
    check("final_queue", exp_q.size(), 0);
    check("final_busy", {31'd0, busy_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
